// File: rtl/serial_addsub_ctrl_pkg.sv
// serial_addsub_ctrl_pkg: shared state encoding, mode codes and slice width
// for the nibble-serial add/subtract controller.
package serial_addsub_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_addsub_ctrl_nibble_addsub.sv
// nibble_addsub: combinational 4-bit add/subtract slice; m=1 inverts b so the
// caller supplies the +1 of two's-complement subtraction through cin.
module nibble_addsub
    import serial_addsub_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                m,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W-1:0] bx;
    logic [3:0]          lo;
    logic [1:0]          hi;

    // Split at bit 3 so the carry into the sign bit is visible for overflow.
    always_comb begin
        bx   = b ^ {NIBBLE_W{m}};
        lo   = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
        hi   = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, lo[3]};
        s    = {hi[0], lo[2:0]};
        c3   = lo[3];
        cout = hi[1];
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: WIDTH-bit add/subtract computed one nibble per clock,
// LSB first, through a single 4-bit slice with a registered carry chain.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = NIBBLE_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx;
    logic [WIDTH-1:0]    a_sr, b_sr, acc, acc_nxt;
    logic                m_r, c_r;
    logic [NIBBLE_W-1:0] s_sum;
    logic                s_cout, s_c3;
    logic                accept, last;

    nibble_addsub u_slice (
        .a    (a_sr[NIBBLE_W-1:0]),
        .b    (b_sr[NIBBLE_W-1:0]),
        .m    (m_r),
        .cin  (c_r),
        .s    (s_sum),
        .cout (s_cout),
        .c3   (s_c3)
    );

    assign accept = start && (state != S_RUN);
    assign last   = idx == IW'(NIBBLES - 1);
    assign busy   = state == S_RUN;
    assign done   = state == S_DONE;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // New slice sum enters at the top, so after NIBBLES steps the LSB nibble sits at the bottom.
    always_comb begin
        state_nxt = S_IDLE;
        if (accept)
            state_nxt = S_RUN;
        else if (state == S_RUN)
            state_nxt = last ? S_DONE : S_RUN;
        acc_nxt = acc >> NIBBLE_W;
        acc_nxt[WIDTH-1 -: NIBBLE_W] = s_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
            m_r      <= MODE_ADD;
            c_r      <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            idx  <= '0;
            a_sr <= a;
            b_sr <= b;
            m_r  <= mode;
            c_r  <= mode;
        end else if (state == S_RUN) begin
            idx  <= idx + 1'b1;
            a_sr <= a_sr >> NIBBLE_W;
            b_sr <= b_sr >> NIBBLE_W;
            acc  <= acc_nxt;
            c_r  <= s_cout;
            if (last) begin
                result   <= acc_nxt;
                carry    <= s_cout;
                overflow <= s_cout ^ s_c3;
            end
        end
    end

endmodule
